sad_generator: RTL and testbench

//   Produces the per-candidate SAD stream consumed by the inter-prediction

---
 rtl/sad_generator.sv | 152 +++++++++++++++
 tb/tb_sad_generator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_generator.sv
`default_nettype none
// ============================================================================
// Module      : sad_generator
// Description : Accumulates |cur - ref| over a block, PIX_PER_BEAT lanes per
//               beat, and emits one SAD per search candidate via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_generator #(
    parameter int PIX_PER_BEAT = 4,
    parameter int BLK_W        = 16,
    parameter int BLK_H        = 16,
    parameter int NUM_CAND     = 9,
    parameter int SAD_W        = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [8*PIX_PER_BEAT-1:0]                       cur_pix,
    input  logic [8*PIX_PER_BEAT-1:0]                       ref_pix,
    output logic                                            sad_valid,
    input  logic                                            sad_ready,
    output logic [SAD_W-1:0]                                sad,
    output logic [((NUM_CAND > 1) ? $clog2(NUM_CAND) : 1)-1:0] cand_idx,
    output logic                                            busy,
    output logic                                            done
);

    localparam int BEATS  = BLK_W * BLK_H / PIX_PER_BEAT;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CIDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int ACC_W  = SAD_W + 1;
    localparam int SUM_W  = SAD_W + 2;

    localparam logic [CNT_W-1:0]  c_LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CIDX_W-1:0] c_LAST_CAND = CIDX_W'(NUM_CAND - 1);
    localparam logic [SUM_W-1:0]  c_ACC_CAP   = SUM_W'(1) << SAD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_s1_valid;
    logic [7:0]          r_diff [PIX_PER_BEAT];
    logic [7:0]          w_diff [PIX_PER_BEAT];
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_next;
    logic [SUM_W-1:0]    w_lane_sum;
    logic [SUM_W-1:0]    w_acc_sum;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CIDX_W-1:0]   r_cand_idx;
    logic                r_done;
    logic                w_accept;
    logic                w_sad_fire;
    logic                w_last_beat;
    logic                w_last_cand;
    logic                w_run_start;
    logic                w_next_cand;

    assign w_accept    = (r_state == S_ACCUM) && in_valid;
    assign w_sad_fire  = (r_state == S_OUT) && sad_ready;
    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
    assign w_last_cand = (r_cand_idx == c_LAST_CAND);
    assign w_run_start = (r_state == S_IDLE) && start;
    assign w_next_cand = w_sad_fire && !w_last_cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_ACCUM;
            S_ACCUM: if (w_accept && w_last_beat) w_state_next = S_DRAIN;
            // Last beat's lane diffs still sit in stage 1 for one cycle
            S_DRAIN: if (!r_s1_valid) w_state_next = S_OUT;
            S_OUT:   if (sad_ready) w_state_next = w_last_cand ? S_IDLE : S_ACCUM;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < PIX_PER_BEAT; k++) begin
            w_diff[k] = (cur_pix[8*k +: 8] >= ref_pix[8*k +: 8])
                      ? (cur_pix[8*k +: 8] - ref_pix[8*k +: 8])
                      : (ref_pix[8*k +: 8] - cur_pix[8*k +: 8]);
        end
    end

    // Accumulator clamps at 2^SAD_W so the MSB doubles as a sticky overflow flag
    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < PIX_PER_BEAT; k++) begin
            w_lane_sum = w_lane_sum + SUM_W'(r_diff[k]);
        end
        w_acc_sum  = SUM_W'(r_acc) + w_lane_sum;
        w_acc_next = (w_acc_sum > c_ACC_CAP) ? ACC_W'(c_ACC_CAP) : w_acc_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_cand_idx <= '0;
            r_done     <= 1'b0;
            for (int k = 0; k < PIX_PER_BEAT; k++) begin
                r_diff[k] <= '0;
            end
        end else begin
            r_s1_valid <= w_accept;
            r_done     <= w_sad_fire && w_last_cand;
            if (w_accept) begin
                for (int k = 0; k < PIX_PER_BEAT; k++) begin
                    r_diff[k] <= w_diff[k];
                end
            end
            if (w_run_start) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
                r_cand_idx <= '0;
            end else if (w_next_cand) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
                r_cand_idx <= r_cand_idx + 1'b1;
            end else begin
                if (r_s1_valid) r_acc <= w_acc_next;
                if (w_accept)   r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign sad_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign cand_idx  = r_cand_idx;
    assign sad       = r_acc[SAD_W] ? {SAD_W{1'b1}} : r_acc[SAD_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_sad_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_generator
// Description : Scoreboard bench for sad_generator: randomized beats, SADs
//               predicted from plain |cur-ref| sums, checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_generator;

    localparam int NC = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_ready, sad_valid, sad_ready, busy, done;
    logic [31:0] cur_pix, ref_pix;
    logic [15:0] sad;
    logic [3:0]  cand_idx;

    logic        s_start, s_in_valid, s_in_ready, s_sad_valid, s_sad_ready, s_busy, s_done;
    logic [31:0] s_cur, s_ref;
    logic [14:0] s_sad;
    logic [0:0]  s_cand_idx;

    sad_generator u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .cur_pix(cur_pix), .ref_pix(ref_pix), .sad_valid(sad_valid), .sad_ready(sad_ready),
        .sad(sad), .cand_idx(cand_idx), .busy(busy), .done(done)
    );

    sad_generator #(.NUM_CAND(1), .SAD_W(15)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .cur_pix(s_cur), .ref_pix(s_ref), .sad_valid(s_sad_valid), .sad_ready(s_sad_ready),
        .sad(s_sad), .cand_idx(s_cand_idx), .busy(s_busy), .done(s_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_sad_q[$];
    int exp_cand_q[$];
    int lat_q[$];
    bit stall_mode = 1'b0;
    int hold_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Downstream: random ready, or hold ready low 5 cycles per result
    initial begin
        sad_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                if (!sad_valid) begin
                    sad_ready = 1'b0;
                    hold_cnt  = 0;
                end else if (hold_cnt < 5) begin
                    sad_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    sad_ready = 1'b1;
                end
            end else begin
                sad_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: compares every accepted SAD against the scoreboard
    initial begin
        bit          prev_valid, prev_ready, expect_done;
        logic [15:0] prev_sad;
        logic [3:0]  prev_cand;
        int          e, ec;
        prev_valid = 0; prev_ready = 0; expect_done = 0; prev_sad = '0; prev_cand = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid  = 0;
                expect_done = 0;
            end else begin
                if (expect_done) check("done_pulse", done, 1);
                else if (done)   check("spurious_done", done, 0);
                expect_done = 0;
                if (sad_valid && !prev_valid) begin
                    check("in_ready_during_out", in_ready, 0);
                    if (lat_q.size() > 0) check("sad_valid_latency", cyc, lat_q.pop_front());
                    else                  check("unexpected_sad_valid", sad_valid, 0);
                end
                if (sad_valid && prev_valid && !prev_ready) begin
                    check("sad_stable_stall", sad, prev_sad);
                    check("cand_stable_stall", cand_idx, prev_cand);
                end
                if (sad_valid && sad_ready) begin
                    if (exp_sad_q.size() > 0) begin
                        e  = exp_sad_q.pop_front();
                        ec = exp_cand_q.pop_front();
                        check("sad_value", sad, e);
                        check("cand_idx", cand_idx, ec);
                        if (ec == NC - 1) expect_done = 1;
                    end else begin
                        check("unexpected_sad_accept", sad_valid, 0);
                    end
                end
                prev_valid = sad_valid;
                prev_ready = sad_ready;
                prev_sad   = sad;
                prev_cand  = cand_idx;
            end
        end
    end

    task automatic send_beat(input logic [31:0] c, input logic [31:0] r, input bit gaps,
                             output int acc_cyc);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        cur_pix  = c;
        ref_pix  = r;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int mode, input bit gaps, input bit stall, input bit poke,
                       input bit abort);
        logic [31:0] c, r;
        int e, ac, a, b;
        stall_mode = stall;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 0; n < NC; n++) begin
            e = 0;
            for (int bt = 0; bt < 64; bt++) begin
                if (abort && n == 1 && bt == 30) begin
                    in_valid = 1'b0;
                    rst      = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    check("abort_busy", busy, 0);
                    check("abort_sad_valid", sad_valid, 0);
                    check("abort_in_ready", in_ready, 0);
                    check("abort_cand_idx", cand_idx, 0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
                for (int k = 0; k < 4; k++) begin
                    case (mode)
                        1:       begin a = 8'h55;                  b = 8'h55;  end
                        2:       begin a = 8'hFF;                  b = 8'h00;  end
                        3:       begin a = k + 1;                  b = 0;      end
                        4:       begin a = $urandom_range(0, 247); b = a + n;  end
                        default: begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
                    endcase
                    c[8*k +: 8] = a[7:0];
                    r[8*k +: 8] = b[7:0];
                    e += (a > b) ? (a - b) : (b - a);
                end
                start = (poke && n == 0 && bt == 10);
                send_beat(c, r, gaps, ac);
                start = 1'b0;
            end
            in_valid = 1'b0;
            lat_q.push_back(ac + 3);
            exp_sad_q.push_back((e > 65535) ? 65535 : e);
            exp_cand_q.push_back(n);
        end
        for (int t = 0; t < 2000 && busy; t++) @(negedge clk);
        check("run_complete_idle", busy, 0);
    endtask

    task automatic sat_run(input logic [7:0] a, input logic [7:0] b, input logic [31:0] e);
        int cnt, guard;
        @(posedge clk); #1; s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        s_cur      = {4{a}};
        s_ref      = {4{b}};
        s_in_valid = 1'b1;
        cnt = 0;
        guard = 0;
        while (cnt < 64 && guard < 300) begin
            @(negedge clk);
            if (s_in_ready) cnt++;
            guard++;
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("sat_beats_accepted", cnt, 64);
        guard = 0;
        @(negedge clk);
        while (!s_sad_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("sat_sad_valid", s_sad_valid, 1);
        check("sat_sad", s_sad, e);
        check("sat_cand_idx", s_cand_idx, 0);
        @(posedge clk); #1; s_sad_ready = 1'b1;
        @(posedge clk); #1; s_sad_ready = 1'b0;
        @(negedge clk);
        check("sat_done_pulse", s_done, 1);
        check("sat_busy_after", s_busy, 0);
        @(negedge clk);
        check("sat_done_single", s_done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; cur_pix = '0; ref_pix = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_cur = '0; s_ref = '0; s_sad_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_sad_valid", sad_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sad", sad, 0);
        check("reset_cand_idx", cand_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        sat_run(8'h55, 8'h55, 32'h0);
        sat_run(8'hFF, 8'h00, 32'h7FFF);

        run(1, 0, 0, 0, 0);
        run(2, 0, 0, 0, 0);
        run(3, 0, 0, 0, 0);
        run(4, 0, 1, 0, 0);
        run(0, 1, 0, 1, 0);
        run(0, 0, 0, 0, 1);
        run(0, 1, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_sad_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
